// File: rtl/rv_wb_pkg.sv
// Shared types and helpers for the register-file write-back controller:
// load funct3 codes, datapath widths, load-queue entry and load-data extension.
package rv_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [1:0]        addr_lo;
    } ld_entry_t;

    function automatic logic funct3_known(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Unknown load types fall through to the raw word; the caller flags them.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                    input logic [1:0]      lo,
                                                    input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LBU:  return {24'h0, b};
            F3_LHU:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of ALU, load-issue, memory-response, decode and register-file signals.
// Handshakes: a transfer happens on a rising edge where valid (alu_valid /
// ld_issue) and ready are both high; ready never depends on valid.
interface reg_writeback_if;
    import rv_wb_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_result;
    logic              ld_issue;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_rd;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_addr_lo;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              stall;
    logic [REG_AW-1:0] A3;
    logic [XLEN-1:0]   WD3;
    logic              WE3;
    logic              protocol_err;

    modport slave (
        input  alu_valid, alu_rd, alu_result, ld_issue, ld_rd, ld_funct3,
               ld_addr_lo, mem_rvalid, mem_rdata, rs1, rs2,
        output alu_ready, ld_ready, stall, A3, WD3, WE3, protocol_err
    );

    modport master (
        output alu_valid, alu_rd, alu_result, ld_issue, ld_rd, ld_funct3,
               ld_addr_lo, mem_rvalid, mem_rdata, rs1, rs2,
        input  alu_ready, ld_ready, stall, A3, WD3, WE3, protocol_err
    );

endinterface

// File: rtl/load_queue.sv
// Synchronous FIFO of outstanding load descriptors; push is ignored when full,
// pop is ignored when empty. DEPTH must be a power of two so pointers wrap.
module load_queue
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  ld_entry_t push_data_i,
    input  logic      pop_i,
    output ld_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ld_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-side controller: arbitrates load responses and ALU results
// onto the single write port and tracks pending load destinations for stalls.
module reg_writeback
    import rv_wb_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    reg_writeback_if.slave wb
);

    logic [31:0]       busy_q, busy_d;
    logic              hold_v_q, hold_v_d;
    logic [REG_AW-1:0] hold_rd_q, hold_rd_d;
    logic [XLEN-1:0]   hold_data_q, hold_data_d;
    logic [REG_AW-1:0] a3_q, a3_d;
    logic [XLEN-1:0]   wd3_q, wd3_d;
    logic              we3_q, we3_d;
    logic              err_q, err_d;

    ld_entry_t         push_entry, head;
    logic              lq_full, lq_empty;
    logic              ld_push, ld_pop, alu_acc;
    logic [XLEN-1:0]   ld_data;
    logic              wr_en;
    logic [REG_AW-1:0] wr_rd;
    logic [XLEN-1:0]   wr_data;

    assign wb.ld_ready  = !lq_full && !(busy_q[wb.ld_rd] && (wb.ld_rd != '0));
    // A pending load to the same rd blocks the ALU so writes stay in program order.
    assign wb.alu_ready = !hold_v_q && !(busy_q[wb.alu_rd] && (wb.alu_rd != '0));
    assign wb.stall     = busy_q[wb.rs1] | busy_q[wb.rs2];

    assign ld_push = wb.ld_issue && wb.ld_ready;
    assign ld_pop  = wb.mem_rvalid && !lq_empty;
    assign alu_acc = wb.alu_valid && wb.alu_ready;

    assign push_entry.rd      = wb.ld_rd;
    assign push_entry.funct3  = wb.ld_funct3;
    assign push_entry.addr_lo = wb.ld_addr_lo;

    load_queue #(.DEPTH(LD_DEPTH)) u_load_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ld_push),
        .push_data_i (push_entry),
        .pop_i       (ld_pop),
        .head_o      (head),
        .full_o      (lq_full),
        .empty_o     (lq_empty)
    );

    assign ld_data = load_extend(head.funct3, head.addr_lo, wb.mem_rdata);

    always_comb begin
        wr_en       = 1'b0;
        wr_rd       = '0;
        wr_data     = '0;
        hold_v_d    = hold_v_q;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
        if (ld_pop) begin
            wr_en   = 1'b1;
            wr_rd   = head.rd;
            wr_data = ld_data;
            if (alu_acc) begin
                hold_v_d    = 1'b1;
                hold_rd_d   = wb.alu_rd;
                hold_data_d = wb.alu_result;
            end
        end else if (hold_v_q) begin
            wr_en    = 1'b1;
            wr_rd    = hold_rd_q;
            wr_data  = hold_data_q;
            hold_v_d = 1'b0;
        end else if (alu_acc) begin
            wr_en   = 1'b1;
            wr_rd   = wb.alu_rd;
            wr_data = wb.alu_result;
        end

        a3_d  = wr_en ? wr_rd : a3_q;
        wd3_d = wr_en ? wr_data : wd3_q;
        we3_d = wr_en && (wr_rd != '0);

        err_d = err_q | (wb.mem_rvalid && lq_empty) |
                (ld_pop && !funct3_known(head.funct3));

        // Clear first so a same-cycle set to the same rd wins.
        busy_d = busy_q;
        if (ld_pop) busy_d[head.rd] = 1'b0;
        if (ld_push && (wb.ld_rd != '0)) busy_d[wb.ld_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            hold_v_q    <= 1'b0;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
            a3_q        <= '0;
            wd3_q       <= '0;
            we3_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            hold_v_q    <= hold_v_d;
            hold_rd_q   <= hold_rd_d;
            hold_data_q <= hold_data_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            we3_q       <= we3_d;
            err_q       <= err_d;
        end
    end

    assign wb.A3           = a3_q;
    assign wb.WD3          = wd3_q;
    assign wb.WE3          = we3_q;
    assign wb.protocol_err = err_q;

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side controller for the integer register file in the RISC-V core. Collects results from the single-cycle ALU path and from variable-latency data-memory loads, sign/zero-extends load data, arbitrates the single write port, and drives the register file's `A3`/`WD3`/`WE3`. A per-register busy scoreboard produces a decode stall for read-after-load hazards.

## Interface
**Parameters**
- `LD_DEPTH`, default 4: maximum outstanding loads; power of two, at least 2.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `alu_valid` in 1: ALU result offered this cycle.
- `alu_ready` out 1: ALU result accepted when `alu_valid && alu_ready`.
- `alu_rd` in 5: ALU destination register.
- `alu_result` in 32: ALU write data.
- `ld_issue` in 1: load issued to memory this cycle.
- `ld_ready` out 1: load issue accepted when `ld_issue && ld_ready`.
- `ld_rd` in 5: load destination register.
- `ld_funct3` in 3: load type.
- `ld_addr_lo` in 2: byte offset of the load address.
- `mem_rvalid` in 1: load data returned; responses arrive in issue order.
- `mem_rdata` in 32: raw memory word.
- `rs1`, `rs2` in 5 each: source registers of the instruction in decode.
- `stall` out 1: decode must hold.
- `A3` out 5, `WD3` out 32, `WE3` out 1: register-file write port.
- `protocol_err` out 1: sticky error flag.

## Operation
- Load queue: FIFO of {rd, funct3, addr_lo}. Each accepted `ld_issue` pushes one entry. Each `mem_rvalid` pops the head entry and forms write data from `mem_rdata`.
- `ld_ready = !full && !(busy[ld_rd] && ld_rd != 0)`.
- Extension rules, with byte = `mem_rdata[8*addr_lo +: 8]` and half = `mem_rdata[16*addr_lo[1] +: 16]`:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: whole word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Any other funct3: write the whole word and set `protocol_err`.
- Scoreboard: `busy[31:1]`. An accepted load with rd≠0 sets `busy[rd]`. The load writeback for rd clears it. If a set and a clear target the same rd in one cycle, the set wins. `busy[0]` is always 0.
- `stall = busy[rs1] | busy[rs2]`. This is combinational from current state, and x0 never stalls.
- `alu_ready = !hold_full && !(busy[alu_rd] && alu_rd != 0)`. This blocks an ALU write from overtaking a pending load to the same register (WAW).
- Arbitration, one write per cycle, in priority order:
  1. Load response.
  2. ALU hold register.
  3. Direct ALU input.
- When a load response and an ALU result collide, the accepted ALU result moves into the 1-entry hold register. It is written on the next cycle without a load response.
- Any write with destination 0 is still consumed, but drives `WE3=0`.
- `mem_rvalid` with an empty queue: the response is ignored and `protocol_err` is set. It stays set until `rst`.

## Timing
- Write port is registered: an accepted ALU result or load response appears on `A3`/`WD3`/`WE3` in the next cycle. `WE3` is high for exactly one cycle per write.
- The scoreboard clear takes effect in the same edge that registers the write. `stall` for that register drops the cycle the write is presented on the port, so decode reads the new value after the register-file edge.
- Queue full: `ld_ready=0`. A simultaneous pop and push when full is not accepted; the push is refused that cycle.
- Simultaneous push and pop when not full: occupancy is unchanged, and pointers wrap modulo `LD_DEPTH`.
- Reset values: `A3=0`, `WD3=0`, `WE3=0`, `protocol_err=0`, busy all 0, queue empty, hold register empty. So after reset `alu_ready=1`, `ld_ready=1`, `stall=0`.
- Reset mid-operation discards outstanding loads and the held ALU result. The external memory must be reset in the same cycle.

## Structure
- Package `rv_wb_pkg` holds:
  - funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - `XLEN=32` and `REG_AW=5`.
  - The load-queue entry struct.
- One sub-module, `load_queue`: a parameterized synchronous FIFO with push, pop, head, full and empty.
- Extension logic, arbitration, hold register and scoreboard live in `reg_writeback`.

## Test plan
- **ALU write:** `alu_valid`, rd=5, result=0x1234 → next cycle `WE3=1`, `A3=5`, `WD3=0x00001234`; rd=0 gives `WE3=0`.
- **Load extension:** for each case, issue the load, then return `mem_rdata=0x80FF7F01`.
  - LB, offset 1 → `WD3=0x0000007F`.
  - LB, offset 3 → `0xFFFFFF80`.
  - LHU, offset 2 → `0x000080FF`.
  - LH, offset 2 → `0xFFFF80FF`.
  - LW → `0x80FF7F01`.
- **Hazard:** issue a load to rd=7, then rs1=7 → `stall=1` until the load response. Alongside it, ALU rd=7 → `alu_ready=0`; ALU rd=8 → accepted.
- **Collision:** load response for rd=3 and ALU rd=4 in the same cycle → rd=3 written at cycle+1 and rd=4 at cycle+2; `alu_ready=0` in the cycle after the collision.
- **Queue full and ordering:** 4 loads issued to rd=1..4 → `ld_ready=0`; in-order responses write rd 1,2,3,4.
- **Errors:** `mem_rvalid` with the queue empty → no write and `protocol_err=1`. Then `rst` clears it and outputs return to their reset values.
